// File: rtl/aes_path_oram_if.sv
// Chunk-stream bundle between the encryption layer, DRAM and the ORAM backend.
// The slave modport is the encryption layer's view; master is the surrounding system.
`timescale 1ns/1ps
interface aes_path_oram_if #(
  parameter int BEDWidth = 64
);
  logic [BEDWidth-1:0] DRAMReadData;
  logic                DRAMReadDataValid;
  logic                DRAMReadDataReady;
  logic [BEDWidth-1:0] DRAMWriteData;
  logic                DRAMWriteDataValid;
  logic                DRAMWriteDataReady;
  logic [BEDWidth-1:0] BackendRData;
  logic                BackendRValid;
  logic                BackendRReady;
  logic [BEDWidth-1:0] BackendWData;
  logic                BackendWValid;
  logic                BackendWReady;

  modport slave (
    input  DRAMReadData, DRAMReadDataValid,
    output DRAMReadDataReady,
    output DRAMWriteData, DRAMWriteDataValid,
    input  DRAMWriteDataReady,
    output BackendRData, BackendRValid,
    input  BackendRReady,
    input  BackendWData, BackendWValid,
    output BackendWReady
  );

  modport master (
    output DRAMReadData, DRAMReadDataValid,
    input  DRAMReadDataReady,
    input  DRAMWriteData, DRAMWriteDataValid,
    output DRAMWriteDataReady,
    input  BackendRData, BackendRValid,
    output BackendRReady,
    output BackendWData, BackendWValid,
    input  BackendWReady
  );
endinterface

// File: rtl/aes_path_oram.sv
// Counter-mode masking layer between the Path ORAM backend and DRAM.
// Chunk 0 of every bucket is a cleartext IV header; data chunks are XORed with Pad(Key, IV, index).
`timescale 1ns/1ps
module aes_path_oram #(
  parameter int BEDWidth = 64,
  parameter int ORAMB    = 512,
  parameter int ORAMZ    = 5,
  parameter int AESWidth = 128,
  parameter int IVWidth  = 64,
  parameter int JTWidth  = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [AESWidth-1:0] Key,
  aes_path_oram_if.slave      bus,
  output logic [JTWidth-1:0]  JTAG_AES
);

  localparam int BktChunks = 1 + ORAMZ * ORAMB / BEDWidth;
  localparam int IdxWidth  = (BktChunks > 1) ? $clog2(BktChunks) : 1;
  localparam int CtrWidth  = AESWidth - IVWidth;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BktChunks - 1);

  // Folding the key-mixed counter block in half gives a chunk-wide pad.
  function automatic logic [BEDWidth-1:0] pad_fn(
    input logic [AESWidth-1:0] key,
    input logic [IVWidth-1:0]  iv,
    input logic [IdxWidth-1:0] idx
  );
    logic [AESWidth-1:0] s;
    s = key ^ {iv, CtrWidth'(idx)};
    return s[AESWidth-1:BEDWidth] ^ s[BEDWidth-1:0];
  endfunction

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + IdxWidth'(1);
  endfunction

  // Read path state
  logic [BEDWidth-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [IdxWidth-1:0] rd_idx_q, rd_idx_d;
  logic [IVWidth-1:0]  rd_iv_q, rd_iv_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d;

  // Write path state
  logic [BEDWidth-1:0] wdata_q, wdata_d;
  logic                wvalid_q, wvalid_d;
  logic [IdxWidth-1:0] wr_idx_q, wr_idx_d;
  logic [IVWidth-1:0]  wr_iv_q, wr_iv_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;

  logic rd_ready, rd_fire;
  logic wr_ready, wr_fire, dram_w_fire;
  logic [IVWidth-1:0]  new_iv;
  logic [BEDWidth-1:0] wr_hdr;

  assign rd_ready    = ~rvalid_q | bus.BackendRReady;
  assign rd_fire     = bus.DRAMReadDataValid & rd_ready;
  assign wr_ready    = ~wvalid_q | bus.DRAMWriteDataReady;
  assign wr_fire     = bus.BackendWValid & wr_ready;
  assign dram_w_fire = wvalid_q & bus.DRAMWriteDataReady;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rd_idx_d = rd_idx_q;
    rd_iv_d  = rd_iv_q;
    rd_cnt_d = rd_cnt_q;
    if (rvalid_q && bus.BackendRReady) begin
      rvalid_d = 1'b0;
    end
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rd_idx_d = next_idx(rd_idx_q);
      rd_cnt_d = rd_cnt_q + 16'd1;
      if (rd_idx_q == '0) begin
        rdata_d = bus.DRAMReadData;
        rd_iv_d = bus.DRAMReadData[IVWidth-1:0];
      end else begin
        rdata_d = bus.DRAMReadData ^ pad_fn(Key, rd_iv_q, rd_idx_q);
      end
    end
  end

  // A fresh IV per bucket write keeps the pad from ever repeating for one address.
  always_comb begin
    new_iv = bus.BackendWData[IVWidth-1:0] + IVWidth'(1);
    wr_hdr = bus.BackendWData;
    wr_hdr[IVWidth-1:0] = new_iv;
  end

  always_comb begin
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    wr_idx_d = wr_idx_q;
    wr_iv_d  = wr_iv_q;
    wr_cnt_d = wr_cnt_q;
    if (dram_w_fire) begin
      wvalid_d = 1'b0;
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (wr_fire) begin
      wvalid_d = 1'b1;
      wr_idx_d = next_idx(wr_idx_q);
      if (wr_idx_q == '0) begin
        wdata_d = wr_hdr;
        wr_iv_d = new_iv;
      end else begin
        wdata_d = bus.BackendWData ^ pad_fn(Key, wr_iv_q, wr_idx_q);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rd_idx_q <= '0;
      rd_iv_q  <= '0;
      rd_cnt_q <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      wr_idx_q <= '0;
      wr_iv_q  <= '0;
      wr_cnt_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rd_idx_q <= rd_idx_d;
      rd_iv_q  <= rd_iv_d;
      rd_cnt_q <= rd_cnt_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      wr_idx_q <= wr_idx_d;
      wr_iv_q  <= wr_iv_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.DRAMReadDataReady  = rd_ready;
  assign bus.BackendRData       = rdata_q;
  assign bus.BackendRValid      = rvalid_q;
  assign bus.BackendWReady      = wr_ready;
  assign bus.DRAMWriteData      = wdata_q;
  assign bus.DRAMWriteDataValid = wvalid_q;
  assign JTAG_AES               = JTWidth'({rd_cnt_q, wr_cnt_q});

endmodule

// File: tb/tb_aes_path_oram.sv
// Scoreboard bench for aes_path_oram: drivers queue expected chunks, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_aes_path_oram;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [127:0] Key   = '1;
  logic [31:0]  JTAG_AES;

  aes_path_oram_if #(.BEDWidth(64)) bus ();

  aes_path_oram dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Key      (Key),
    .bus      (bus.slave),
    .JTAG_AES (JTAG_AES)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  logic [63:0] rd_exp[$];
  logic [63:0] wr_exp[$];
  logic [63:0] rd_e, wr_e;
  logic [63:0] p[41];
  logic [63:0] c[41];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitors: a chunk is consumed on valid&&ready at the coming edge.
  always @(negedge Clock) begin
    if (!Reset && bus.BackendRValid && bus.BackendRReady) begin
      if (rd_exp.size() == 0) begin
        chk("rd_unexpected", bus.BackendRData, 64'hx);
      end else begin
        rd_e = rd_exp.pop_front();
        chk("rd_data", bus.BackendRData, rd_e);
        $display("rd out %h exp %h", bus.BackendRData, rd_e);
      end
    end
    if (!Reset && bus.DRAMWriteDataValid && bus.DRAMWriteDataReady) begin
      if (wr_exp.size() == 0) begin
        chk("wr_unexpected", bus.DRAMWriteData, 64'hx);
      end else begin
        wr_e = wr_exp.pop_front();
        chk("wr_data", bus.DRAMWriteData, wr_e);
        $display("wr out %h exp %h", bus.DRAMWriteData, wr_e);
      end
    end
  end

  task automatic send_rd(input logic [63:0] d, input logic [63:0] e);
    bit ok = 0;
    rd_exp.push_back(e);
    bus.DRAMReadData      = d;
    bus.DRAMReadDataValid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clock);
      if (bus.DRAMReadDataReady) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rd_accept_timeout", 64'd0, 64'd1);
    @(posedge Clock);
    #1;
    bus.DRAMReadDataValid = 1'b0;
  endtask

  task automatic send_wr(input logic [63:0] d, input logic [63:0] e);
    bit ok = 0;
    wr_exp.push_back(e);
    bus.BackendWData  = d;
    bus.BackendWValid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clock);
      if (bus.BackendWReady) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wr_accept_timeout", 64'd0, 64'd1);
    @(posedge Clock);
    #1;
    bus.BackendWValid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge Clock);
      #1;
      if (rd_exp.size() == 0 && wr_exp.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'(rd_exp.size() + wr_exp.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    rd_exp.delete();
    wr_exp.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DRAMReadData       = '0;
    bus.DRAMReadDataValid  = 1'b0;
    bus.DRAMWriteDataReady = 1'b1;
    bus.BackendRReady      = 1'b1;
    bus.BackendWData       = '0;
    bus.BackendWValid      = 1'b0;

    // 1: reset state
    do_reset();
    chk("rst_rvalid", 64'(bus.BackendRValid), 64'd0);
    chk("rst_wvalid", 64'(bus.DRAMWriteDataValid), 64'd0);
    chk("rst_rd_ready", 64'(bus.DRAMReadDataReady), 64'd1);
    chk("rst_w_ready", 64'(bus.BackendWReady), 64'd1);
    chk("rst_jtag", 64'(JTAG_AES), 64'd0);
    chk("rst_rdata", bus.BackendRData, 64'd0);

    // 2: read header IV=5 then zero chunk; valid one cycle after acceptance
    send_rd(64'd5, 64'd5);
    chk("rd_lat_valid", 64'(bus.BackendRValid), 64'd1);
    chk("rd_lat_hdr", bus.BackendRData, 64'd5);
    send_rd(64'd0, 64'd4);
    chk("rd_lat_chunk", bus.BackendRData, 64'd4);
    drain();

    // 3: write header IV=5 -> 6, chunk 0 -> 6^1; max IV wraps to 0
    do_reset();
    send_wr(64'd5, 64'd6);
    chk("wr_lat_valid", 64'(bus.DRAMWriteDataValid), 64'd1);
    send_wr(64'd0, 64'd7);
    drain();
    do_reset();
    send_wr(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    send_wr(64'h10, 64'h11);
    drain();

    // 4: write a whole bucket while reading back its ciphertext concurrently
    do_reset();
    p[0] = 64'd5;
    c[0] = 64'd6;
    for (int i = 1; i < 41; i++) begin
      p[i] = {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h0101_0101};
      c[i] = p[i] ^ (64'd6 ^ 64'(i));
    end
    fork
      begin
        for (int i = 0; i < 41; i++) send_wr(p[i], c[i]);
      end
      begin
        send_rd(c[0], 64'd6);
        for (int i = 1; i < 41; i++) send_rd(c[i], p[i]);
      end
    join
    send_rd(64'd9, 64'd9);
    send_rd(64'd0, 64'd8);
    send_wr(64'h20, 64'h21);
    drain();

    // 5: backpressure on the read output
    do_reset();
    bus.BackendRReady = 1'b0;
    send_rd(64'd3, 64'd3);
    fork
      send_rd(64'h10, 64'h10 ^ 64'd2);
      begin
        repeat (3) begin
          @(negedge Clock);
          chk("hold_ready", 64'(bus.DRAMReadDataReady), 64'd0);
          chk("hold_data", bus.BackendRData, 64'd3);
        end
        @(posedge Clock);
        #1;
        bus.BackendRReady = 1'b1;
      end
    join
    drain();

    // 6: reset at chunk 20 of the read bucket, then a fresh header
    do_reset();
    send_rd(64'h20, 64'h20);
    for (int i = 1; i < 20; i++) send_rd(64'd0, 64'h20 ^ 64'(i));
    drain();
    chk("jtag_pre", 64'(JTAG_AES), 64'h0014_0000);
    do_reset();
    chk("jtag_rst", 64'(JTAG_AES), 64'd0);
    send_rd(64'd7, 64'd7);
    send_rd(64'd0, 64'd6);
    send_wr(64'd7, 64'd8);
    send_wr(64'd0, 64'd9);
    send_wr(64'hFF, 64'hF5);
    drain();
    chk("jtag_post", 64'(JTAG_AES), 64'h0002_0003);
    chk("queues_empty", 64'(rd_exp.size() + wr_exp.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
